// File: rtl/kp_scanner.sv
// kp_scanner: keypad column scanner with row synchronizer, post-switch
// blanking and press/release debouncing in front of the keypad decoder.
module kp_scanner #(
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned DEBOUNCE_TICKS = 20
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] kpr,
    output logic [3:0] kpc,
    output logic [3:0] kpr_q,
    output logic       kp_valid,
    output logic       kp_press
);

    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam int unsigned DEB_W = $clog2(DEBOUNCE_TICKS + 1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       kpr_m;
    logic [3:0]       kpr_s;
    logic [3:0]       kpr_v;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [1:0]       blank_cnt;
    logic [3:0]       cap;
    logic [3:0]       cap_nxt;
    logic [DEB_W-1:0] deb_cnt;
    logic [DEB_W-1:0] deb_nxt;
    logic [DEB_W-1:0] deb_inc;
    logic             deb_last;
    logic             row_idle;
    logic             row_onehot;
    logic             row_bad;
    logic             rotate;
    logic [3:0]       kpc_nxt;
    logic [3:0]       kpr_q_nxt;
    logic             valid_nxt;
    logic             press_nxt;

    assign tick       = (div_cnt == DIV_W'(SCAN_DIV - 1));
    assign kpr_v      = (blank_cnt != 2'd0) ? 4'b1111 : kpr_s;
    assign row_idle   = (kpr_v == 4'b1111);
    assign row_onehot = $onehot(~kpr_v);
    assign row_bad    = !row_idle && !row_onehot;
    assign deb_last   = (deb_cnt == DEB_W'(DEBOUNCE_TICKS - 1));
    assign deb_inc    = (deb_cnt == DEB_W'(DEBOUNCE_TICKS)) ? deb_cnt : deb_cnt + DEB_W'(1);

    // Two-flop synchronizer for the asynchronous row inputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            kpr_m <= 4'b1111;
            kpr_s <= 4'b1111;
        end else begin
            kpr_m <= kpr;
            kpr_s <= kpr_m;
        end
    end

    // Free-running scan tick divider, independent of the FSM
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Mask rows for three cycles after a column switch (covers synchronizer lag)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blank_cnt <= 2'd0;
        end else if (rotate) begin
            blank_cnt <= 2'd3;
        end else if (blank_cnt != 2'd0) begin
            blank_cnt <= blank_cnt - 2'd1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= SCAN;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            SCAN: begin
                if (row_onehot) state_nxt = DEBOUNCE;
            end
            DEBOUNCE: begin
                if (row_idle) begin
                    state_nxt = SCAN;
                end else if (!row_bad && (kpr_v == cap) && tick && deb_last) begin
                    state_nxt = PRESSED;
                end
            end
            PRESSED: begin
                if (row_idle) state_nxt = RELEASE;
            end
            RELEASE: begin
                if (!row_idle) begin
                    state_nxt = PRESSED;
                end else if (tick && deb_last) begin
                    state_nxt = SCAN;
                end
            end
            default: state_nxt = SCAN;
        endcase
    end

    // FSM datapath/output decode: next values for column, capture, counter and outputs
    always_comb begin
        kpc_nxt   = kpc;
        kpr_q_nxt = kpr_q;
        valid_nxt = kp_valid;
        press_nxt = 1'b0;
        cap_nxt   = cap;
        deb_nxt   = deb_cnt;
        rotate    = 1'b0;
        case (state)
            SCAN: begin
                if (row_onehot) begin
                    cap_nxt = kpr_v;
                    deb_nxt = '0;
                end else if (tick && row_idle) begin
                    rotate  = 1'b1;
                    kpc_nxt = {kpc[0], kpc[3:1]};
                end
            end
            DEBOUNCE: begin
                if (row_idle || row_bad) begin
                    deb_nxt = '0;
                end else if (kpr_v != cap) begin
                    cap_nxt = kpr_v;
                    deb_nxt = '0;
                end else if (tick) begin
                    deb_nxt = deb_inc;
                    if (deb_last) begin
                        kpr_q_nxt = cap;
                        valid_nxt = 1'b1;
                        press_nxt = 1'b1;
                    end
                end
            end
            PRESSED: begin
                if (row_idle) deb_nxt = '0;
            end
            RELEASE: begin
                if (!row_idle) begin
                    deb_nxt = '0;
                end else if (tick) begin
                    deb_nxt = deb_inc;
                    if (deb_last) begin
                        valid_nxt = 1'b0;
                        kpr_q_nxt = 4'b1111;
                    end
                end
            end
            default: ;
        endcase
    end

    // Registered datapath and outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            kpc      <= 4'b0111;
            kpr_q    <= 4'b1111;
            kp_valid <= 1'b0;
            kp_press <= 1'b0;
            cap      <= 4'b1111;
            deb_cnt  <= '0;
        end else begin
            kpc      <= kpc_nxt;
            kpr_q    <= kpr_q_nxt;
            kp_valid <= valid_nxt;
            kp_press <= press_nxt;
            cap      <= cap_nxt;
            deb_cnt  <= deb_nxt;
        end
    end

endmodule

// File: tb/tb_kp_scanner.sv
// Bench for kp_scanner: behavioural keypad/scanner model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_kp_scanner;

    localparam int unsigned DIV = 8;
    localparam int unsigned DT  = 3;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] kpr;
    logic [3:0] kpc;
    logic [3:0] kpr_q;
    logic       kp_valid;
    logic       kp_press;

    kp_scanner #(.SCAN_DIV(DIV), .DEBOUNCE_TICKS(DT)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .kpr      (kpr),
        .kpc      (kpc),
        .kpr_q    (kpr_q),
        .kp_valid (kp_valid),
        .kp_press (kp_press)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_min(input string name, input int act, input int lo);
        checks++;
        if (act < lo) begin
            errors++;
            $display("FAIL %s: got %0d expected at least %0d", name, act, lo);
        end
    endtask

    function automatic logic [3:0] col_drive(input int c);
        logic [3:0] one;
        one = 4'b1000 >> c;
        return ~one;
    endfunction

    // ---------------- behavioural model ----------------
    localparam int M_IDLE   = 0;   // scanning columns
    localparam int M_SETTLE = 1;   // waiting for a stable row
    localparam int M_HELD   = 2;   // key accepted
    localparam int M_LETGO  = 3;   // waiting for a stable release

    int         m_cyc;             // clock edges since reset
    int         m_col;             // active column index, 0 = kpc 0111
    int         m_since;           // edges since the last column switch
    int         m_mode;
    int         m_cnt;             // stable ticks seen
    logic [3:0] m_s1, m_s2;        // raw row samples, one and two edges old
    logic [3:0] m_cap;
    logic [3:0] m_q;
    logic       m_valid;
    logic       m_press;

    task automatic model_reset();
        m_cyc = 0; m_col = 0; m_since = 3; m_mode = M_IDLE; m_cnt = 0;
        m_s1 = 4'hF; m_s2 = 4'hF; m_cap = 4'hF; m_q = 4'hF;
        m_valid = 1'b0; m_press = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] raw);
        logic [3:0] v;
        bit         tick;
        bit         rot;
        int         z;
        v    = (m_since < 3) ? 4'hF : m_s2;
        tick = ((m_cyc % DIV) == DIV - 1);
        z    = $countones(~v);
        rot  = 1'b0;
        m_press = 1'b0;
        case (m_mode)
            M_IDLE: begin
                if (z == 1) begin
                    m_mode = M_SETTLE; m_cap = v; m_cnt = 0;
                end else if (z == 0 && tick) begin
                    rot = 1'b1;
                end
            end
            M_SETTLE: begin
                if (z == 0) begin
                    m_mode = M_IDLE; m_cnt = 0;
                end else if (z > 1) begin
                    m_cnt = 0;
                end else if (v != m_cap) begin
                    m_cap = v; m_cnt = 0;
                end else if (tick) begin
                    m_cnt++;
                    if (m_cnt == DT) begin
                        m_mode = M_HELD; m_q = m_cap; m_valid = 1'b1; m_press = 1'b1;
                    end
                end
            end
            M_HELD: begin
                if (z == 0) begin
                    m_mode = M_LETGO; m_cnt = 0;
                end
            end
            default: begin
                if (z != 0) begin
                    m_mode = M_HELD; m_cnt = 0;
                end else if (tick) begin
                    m_cnt++;
                    if (m_cnt == DT) begin
                        m_mode = M_IDLE; m_valid = 1'b0; m_q = 4'hF;
                    end
                end
            end
        endcase
        if (rot) begin
            m_col = (m_col + 1) % 4;
            m_since = 0;
        end else if (m_since < 3) begin
            m_since++;
        end
        m_s2 = m_s1;
        m_s1 = raw;
        m_cyc++;
    endtask

    // Advance the model and compare every cycle on the falling edge
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (!reset_n) model_reset();
            else          model_step(kpr);
            check4("kpc",      kpc,      col_drive(m_col));
            check4("kpr_q",    kpr_q,    m_q);
            check1("kp_valid", kp_valid, m_valid);
            check1("kp_press", kp_press, m_press);
        end
    end

    // ---------------- keypad stimulus ----------------
    logic [3:0] key_kpc;
    logic [3:0] key_row;
    logic       contact;
    logic       ovr_en;
    logic [3:0] ovr_val;
    int         n_press;
    int         n_chg;
    logic [3:0] kpc_prev;

    task automatic step();
        @(negedge clk);
        #1;
        if (ovr_en)                         kpr = ovr_val;
        else if (contact && kpc == key_kpc) kpr = key_row;
        else                                kpr = 4'hF;
        if (kp_press) n_press++;
        if (kpc != kpc_prev) n_chg++;
        kpc_prev = kpc;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0; kpr = 4'hF; contact = 1'b0; ovr_en = 1'b0; ovr_val = 4'hF;
        key_kpc = 4'b1011; key_row = 4'b1011;
        n_press = 0; n_chg = 0; kpc_prev = 4'b0111;
        repeat (3) step();
        check4("rst_kpc", kpc, 4'b0111);
        check4("rst_kpr_q", kpr_q, 4'b1111);
        check1("rst_valid", kp_valid, 1'b0);
        reset_n = 1'b1;

        // first column change lands on the 8th edge after reset release
        repeat (7) step();
        check4("first_tick_hold", kpc, 4'b0111);
        step();
        check4("first_tick_move", kpc, 4'b1011);

        // idle scan
        n_press = 0;
        repeat (40) step();
        check_int("idle_press_count", n_press, 0);
        check4("idle_kpc_after_48", kpc, 4'b1101);

        // clean press of key 5
        contact = 1'b1; n_press = 0;
        repeat (120) step();
        check_int("clean_press_count", n_press, 1);
        check4("clean_kpr_q", kpr_q, 4'b1011);
        check1("clean_valid", kp_valid, 1'b1);
        check4("clean_kpc_frozen", kpc, 4'b1011);
        n_press = 0;
        repeat (100) step();
        check_int("held_extra_press", n_press, 0);

        // release with a 2-cycle glitch
        contact = 1'b0; n_press = 0;
        repeat (6) step();
        contact = 1'b1;
        repeat (2) step();
        contact = 1'b0;
        repeat (10) step();
        check1("glitch_valid_held", kp_valid, 1'b1);
        n_chg = 0;
        repeat (60) step();
        check1("release_valid", kp_valid, 1'b0);
        check4("release_kpr_q", kpr_q, 4'b1111);
        check_int("release_press_count", n_press, 0);
        check_min("release_rotation", n_chg, 1);

        // press bounce then stable hold
        n_press = 0;
        for (int i = 0; i < 6; i++) begin
            contact = (i % 2 == 0);
            repeat (5) step();
        end
        check_int("bounce_press_count", n_press, 0);
        contact = 1'b1; n_press = 0;
        repeat (120) step();
        check_int("bounce_hold_press", n_press, 1);
        contact = 1'b0;
        repeat (60) step();
        check1("bounce_released", kp_valid, 1'b0);

        // two rows together in column 1101
        key_kpc = 4'b1101; key_row = 4'b1001; contact = 1'b1; n_press = 0;
        repeat (80) step();
        check_int("multi_press_count", n_press, 0);
        check4("multi_kpr_q", kpr_q, 4'b1111);
        check1("multi_valid", kp_valid, 1'b0);
        check4("multi_kpc_blocked", kpc, 4'b1101);
        contact = 1'b0;
        repeat (20) step();

        // row seen by the synchronizer only inside the blanking window
        for (int i = 0; i < 16; i++) begin
            if ((m_cyc % DIV) == DIV - 1) break;
            step();
        end
        n_chg = 0; n_press = 0;
        ovr_en = 1'b1; ovr_val = 4'b1110; kpr = ovr_val;
        step();
        ovr_en = 1'b0;
        repeat (20) step();
        check_int("blank_press_count", n_press, 0);
        check1("blank_valid", kp_valid, 1'b0);
        check_min("blank_rotations", n_chg, 2);

        // asynchronous reset while a key is held
        key_kpc = 4'b1011; key_row = 4'b1011; contact = 1'b1;
        repeat (120) step();
        check1("pre_reset_valid", kp_valid, 1'b1);
        reset_n = 1'b0;
        #1;
        check4("async_kpc", kpc, 4'b0111);
        check4("async_kpr_q", kpr_q, 4'b1111);
        check1("async_valid", kp_valid, 1'b0);
        check1("async_press", kp_press, 1'b0);
        step(); step();
        reset_n = 1'b1;
        contact = 1'b0;
        repeat (60) step();

        // random keys, bounces, glitches and resets
        for (int ep = 0; ep < 40; ep++) begin
            key_kpc = col_drive(int'($urandom_range(0, 3)));
            if ($urandom_range(0, 4) == 0) begin
                key_row = 4'($urandom_range(0, 14));
            end else begin
                key_row = col_drive(int'($urandom_range(0, 3)));
            end
            for (int s = 0; s < int'($urandom_range(1, 6)); s++) begin
                contact = 1'($urandom_range(0, 1));
                repeat ($urandom_range(1, 30)) step();
            end
            if ($urandom_range(0, 7) == 0) begin
                ovr_en = 1'b1; ovr_val = 4'($urandom);
                step();
                ovr_en = 1'b0;
            end
            contact = 1'b1;
            repeat ($urandom_range(0, 80)) step();
            contact = 1'b0;
            repeat ($urandom_range(0, 60)) step();
            if ($urandom_range(0, 9) == 0) begin
                reset_n = 1'b0;
                step();
                reset_n = 1'b1;
            end
        end
        repeat (5) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/kp_scanner.md
Name: kp_scanner

Overview:
- Keypad front end that sits directly upstream of the keypad decoder.
- Drives the keypad columns one at a time (active-low) and synchronizes the raw row inputs.
- Freezes the scan and debounces when a key is pressed.
- Presents a stable column/row pair to the decoder, with a level-valid flag and a single-cycle press pulse.

Parameters:
SCAN_DIV, 50000, clk cycles per scan tick (column dwell time); must be >= 8
DEBOUNCE_TICKS, 20, consecutive stable scan ticks required to accept a press or a release; must be >= 1

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous, active-low reset
kpr  input  4  raw keypad rows, active-low, pulled up, asynchronous to clk
kpc  output  4  column drive to keypad and decoder, exactly one bit low (registered)
kpr_q  output  4  debounced row pattern to decoder; 4'b1111 when no valid key
kp_valid  output  1  high while a debounced key is held
kp_press  output  1  one-clk pulse per accepted press

Behaviour:
- Clock/reset: one clock (clk). Reset is asynchronous and active-low (reset_n), applies immediately at any point including mid-press, and sets:
  - kpc=0111, kpr_q=1111, kp_valid=0, kp_press=0
  - both synchronizer stages=1111, state=SCAN, all counters=0
- Synchronizer: two flops on kpr; kpr_s = second stage. Logic uses only kpr_s (2-cycle latency).
- Tick: free-running divider counts 0..SCAN_DIV-1 and wraps. tick=1 for one cycle at SCAN_DIV-1. The divider is never cleared by state changes.
- Blanking: for 3 cycles after any kpc change, kpr_s is ignored (treated as 1111) so stale rows from the previous column are never attributed to the new one.
- One-hot row: kpr_s has exactly one 0 bit. Any other non-1111 pattern (multi-row) is "invalid".
- FSM states: SCAN, DEBOUNCE, PRESSED, RELEASE.
- SCAN:
  - kpr_s (unblanked) one-hot-row -> DEBOUNCE: cap<=kpr_s, deb_cnt<=0, kpc held.
  - Else on tick, rotate kpc 0111->1011->1101->1110->0111.
  - Invalid patterns keep SCAN and block rotation while present.
- DEBOUNCE (kpc held):
  - Any cycle kpr_s==1111 -> SCAN, deb_cnt<=0, no rotation that cycle.
  - Any cycle kpr_s!=cap and one-hot -> cap<=kpr_s, deb_cnt<=0.
  - Invalid pattern -> deb_cnt<=0, stay.
  - Tick with kpr_s==cap -> deb_cnt++.
  - On reaching DEBOUNCE_TICKS -> PRESSED, with registered next-cycle outputs: kpr_q<=cap, kp_valid<=1, kp_press<=1 for exactly one cycle.
- PRESSED (kpc and kpr_q held):
  - kpr_s changes to another non-1111 pattern -> ignored, no second press.
  - kpr_s==1111 -> RELEASE, deb_cnt<=0.
- RELEASE (kp_valid stays 1):
  - Any non-1111 cycle -> PRESSED, deb_cnt<=0.
  - Tick with kpr_s==1111 -> deb_cnt++.
  - On reaching DEBOUNCE_TICKS -> SCAN, kp_valid<=0, kpr_q<=1111. Rotation resumes on the next tick.
- Invariant: kp_press only rises on the DEBOUNCE->PRESSED transition; at most one pulse per press/release cycle.
- Widths: divider ceil(log2(SCAN_DIV)) bits; deb_cnt ceil(log2(DEBOUNCE_TICKS+1)) bits, saturating at terminal value.

Test Plan:
1. Reset checks (SCAN_DIV=8, DEBOUNCE_TICKS=3 for all tests):
   - Assert reset_n=0 mid-run -> kpc=0111, kpr_q=1111, kp_valid=0, kp_press=0 asynchronously.
   - Release reset -> kpc first changes to 1011 at the first tick.
2. Idle scan: kpr=1111 for 40 cycles -> kpc cycles 0111,1011,1101,1110,0111 changing every 8 cycles; kp_press never 1.
3. Clean press of key 5 (keypad model drives kpr=1011 only while kpc==1011):
   - Scan freezes at kpc=1011.
   - After 3 stable ticks: exactly one kp_press pulse, kpr_q=1011, kp_valid=1.
   - Held 100 cycles -> no further pulses.
4. Press bounce: toggle kpr 1011/1111 every 5 cycles for 30 cycles, then hold 1011 -> no pulse during bouncing; a single pulse 3 ticks after the stable hold begins.
5. Release bounce: from PRESSED, release with one 2-cycle glitch to 1011 -> kp_valid stays 1 until 3 clean ticks after the glitch. Then kp_valid=0, kpr_q=1111, kpc resumes rotating; no extra kp_press.
6. Multi-key and stale rows:
   - kpr=1001 in column 1101 -> no kp_press, kpr_q stays 1111.
   - Row asserted only for the 2 cycles after a kpc change (blanking window) -> ignored, scan continues.
